video_scanout: RTL and testbench
================================

// Module: video_scanout
// PURPOSE
//  Downstream of the console: captures the PPU pixel stream (pixel number + 6-bit NES colour index) into an
//  on-chip 256x240 frame buffer. Scans it out as 15 kHz RGB video with hsync/vsync/de.
//  Runs on the 10.74 MHz PPU clock with a dot enable every CLK_DIV cycles. Colour index -> 12-bit RGB via internal palette ROM.
// PARAMETERS
//  CLK_DIV      2    clk cycles per output dot (10.74 MHz / 2 = 5.37 MHz dot rate)
//  H_ACTIVE     256  visible dots per line
//  H_FP         16   horizontal front porch, dots
//  H_SYNC       25   hsync width, dots
//  H_BP         44   horizontal back porch, dots (total 341)
//  V_ACTIVE     240  visible lines
//  V_FP         3    vertical front porch, lines
//  V_SYNC       3    vsync width, lines
//  V_BP         16   vertical back porch, lines (total 262)
//  OVERSCAN     0    lines blanked (rgb forced 0, de still 1) at top and at bottom of active area
//  SYNC_LOW     1    1: hsync/vsync active-low; 0: active-high
// PORTS
//  clk          in   1   10.74 MHz system clock
//  reset        in   1   synchronous, active-high
//  pixel_num    in   16  write address {y[7:0], x[7:0]}, from console
//  pixel_color  in   6   NES colour index to store
//  pixel_write  in   1   write strobe, one clk wide, any cycle
//  rgb          out  12  {r[3:0], g[3:0], b[3:0]}
//  hsync        out  1   horizontal sync, polarity per SYNC_LOW
//  vsync        out  1   vertical sync, polarity per SYNC_LOW
//  de           out  1   1 during visible dots
//  frame_start  out  1   one-clk pulse aligned with first visible dot (x=0, y=0) at output
// BEHAVIOUR
//  - Reset: dot_div=0, hcnt=0, vcnt=0, pipeline flushed; rgb=0, de=0, frame_start=0, syncs inactive. Buffer not cleared.
//  - Reset mid-frame: counters restart at (0,0) on the first cycle after reset deasserts; no partial sync pulse glitch.
//  - Frame buffer: 61440 x 6 bit, simple dual-port. Write port: pixel_write & pixel_num < 16'hF000 -> mem[pixel_num]<=pixel_color.
//    Writes with pixel_num >= 16'hF000 are ignored. Writes are never blocked by scanout.
//  - Read/write same address in same clk: read returns the OLD value (read-first).
//  - Timing: dot_en when dot_div==CLK_DIV-1; dot_div wraps to 0. On dot_en hcnt++, wraps at 340 -> 0, then vcnt++.
//    vcnt wraps at 261 -> 0.
//  - Regions (hcnt): [0,255] active, [256,271] FP, [272,296] sync, [297,340] BP.
//    Regions (vcnt): [0,239] active, [240,242] FP, [243,245] sync, [246,261] BP.
//  - Pipeline, fixed 3 clk from counter state to outputs: S0 address {vcnt[7:0],hcnt[7:0]} registered;
//    S1 buffer read data; S2 palette ROM lookup registered to rgb. hsync/vsync/de/frame_start delayed 3 clk to match.
//  - Each dot held CLK_DIV clk on outputs; outputs update only on delayed dot_en, stable otherwise.
//  - rgb=0 whenever de=0 or the line is in overscan (vcnt<OVERSCAN or vcnt>=V_ACTIVE-OVERSCAN).
//  - Palette: 64-entry ROM, standard 2C02 colours reduced to 4 bits/channel; indices 0x0D,0x1D,0x2D,0x3D,0x0E,0x1E,
//    0x2E,0x3E,0x0F,0x1F,0x2F,0x3F -> 12'h000; 0x30 -> 12'hFFF.
//  - No handshake/backpressure: pixel stream is fire-and-forget; tearing is acceptable (no double buffer).
// TESTING
//  1 Reset 5 clk, release: count clk from release to first frame_start; de rising = 3 clk + row/col 0 timing;
//    frame period 341*262*2 = 178684 clk.
//  2 Sync: hsync low for exactly 25*2=50 clk per line starting at hcnt=272 (+3 pipeline); vsync low for 3 lines = 2046 clk.
//  3 Write pixel_num=16'h0000 color=6'h30, 16'h00FF color=6'h0F, 16'hEFFF color=6'h30: scan shows
//    rgb=FFF at (0,0), 000 at (255,0), FFF at (255,239).
//  4 Write pixel_num=16'hF000 color=6'h30: no buffer location changes; full-frame checksum unchanged vs. previous frame.
//  5 Write to address being read that same clk: output shows old colour this frame, new colour next frame.
//  6 OVERSCAN=8: lines 0-7 and 232-239 output rgb=0 with de=1, line 8 shows buffer content;
//    reset asserted at vcnt=100 restarts cleanly at (0,0).

Source files
------------

// File: rtl/video_scanout_if.sv
// video_scanout_if: console pixel write stream in, timed RGB video out
interface video_scanout_if;
  logic [15:0] pixel_num;
  logic [5:0]  pixel_color;
  logic        pixel_write;
  logic [11:0] rgb;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        frame_start;
  modport master (
    output pixel_num, pixel_color, pixel_write,
    input  rgb, hsync, vsync, de, frame_start
  );
  modport slave (
    input  pixel_num, pixel_color, pixel_write,
    output rgb, hsync, vsync, de, frame_start
  );
endinterface

// File: rtl/video_scanout.sv
// video_scanout: captures PPU pixels into a 256x240 frame buffer and scans it out as 15 kHz RGB video
module video_scanout #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 256,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 25,
  parameter int H_BP     = 44,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 16,
  parameter int OVERSCAN = 0,
  parameter int SYNC_LOW = 1
) (
  input logic            clk,
  input logic            reset,
  video_scanout_if.slave vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic SL = SYNC_LOW != 0;
  localparam logic [11:0] PAL [64] = '{
    12'h777, 12'h00F, 12'h00B, 12'h42B, 12'h908, 12'hA02, 12'hA10, 12'h810,
    12'h530, 12'h070, 12'h060, 12'h050, 12'h045, 12'h000, 12'h000, 12'h000,
    12'hBBB, 12'h07F, 12'h05F, 12'h64F, 12'hD0C, 12'hE05, 12'hF30, 12'hE51,
    12'hA70, 12'h0B0, 12'h0A0, 12'h0A4, 12'h088, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h3BF, 12'h68F, 12'h97F, 12'hF7F, 12'hF59, 12'hF75, 12'hFA4,
    12'hFB0, 12'hBF1, 12'h5D5, 12'h5F9, 12'h0ED, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'hAEF, 12'hBBF, 12'hDBF, 12'hFBF, 12'hFAC, 12'hFDB, 12'hFEA,
    12'hFD7, 12'hDF7, 12'hBFB, 12'hBFD, 12'h0FF, 12'h000, 12'h000, 12'h000
  };
  typedef struct packed {
    logic start;
    logic fs;
    logic de;
    logic hs;
    logic vs;
    logic blank;
  } ctl_t;
  logic [DW-1:0] dot_div;
  logic [9:0]    hcnt;
  logic [9:0]    vcnt;
  logic          dot_en;
  ctl_t          ctl_n;
  ctl_t          s0_ctl;
  ctl_t          s1_ctl;
  logic [15:0]   s0_addr;
  logic [5:0]    s1_color;
  logic [5:0]    mem [0:61439];
  assign dot_en = dot_div == DW'(CLK_DIV - 1);
  always_ff @(posedge clk)
    if (reset) begin
      dot_div <= '0;
      hcnt    <= '0;
      vcnt    <= '0;
    end else begin
      dot_div <= dot_en ? '0 : dot_div + 1'b1;
      if (dot_en) begin
        hcnt <= hcnt == 10'(H_TOTAL - 1) ? '0 : hcnt + 1'b1;
        if (hcnt == 10'(H_TOTAL - 1))
          vcnt <= vcnt == 10'(V_TOTAL - 1) ? '0 : vcnt + 1'b1;
      end
    end
  // start marks the first clk of a dot; only that copy reaches the output registers
  always_comb begin
    ctl_n.start = dot_div == '0;
    ctl_n.fs    = hcnt == '0 && vcnt == '0;
    ctl_n.de    = hcnt < 10'(H_ACTIVE) && vcnt < 10'(V_ACTIVE);
    ctl_n.hs    = hcnt >= 10'(H_ACTIVE + H_FP) && hcnt < 10'(H_ACTIVE + H_FP + H_SYNC);
    ctl_n.vs    = vcnt >= 10'(V_ACTIVE + V_FP) && vcnt < 10'(V_ACTIVE + V_FP + V_SYNC);
    ctl_n.blank = !ctl_n.de || vcnt + 10'd1 <= 10'(OVERSCAN) || vcnt >= 10'(V_ACTIVE - OVERSCAN);
  end
  always_ff @(posedge clk)
    if (reset) begin
      s0_ctl  <= '0;
      s1_ctl  <= '0;
      s0_addr <= '0;
    end else begin
      s0_ctl  <= ctl_n;
      s1_ctl  <= s0_ctl;
      s0_addr <= ctl_n.de ? {vcnt[7:0], hcnt[7:0]} : '0;
    end
  // read-first: a same-clk write to the scanned address is seen next frame
  always_ff @(posedge clk) begin
    s1_color <= mem[s0_addr];
    if (vid.pixel_write && vid.pixel_num < 16'hF000)
      mem[vid.pixel_num] <= vid.pixel_color;
  end
  always_ff @(posedge clk)
    if (reset) begin
      vid.rgb         <= '0;
      vid.de          <= 1'b0;
      vid.hsync       <= SL;
      vid.vsync       <= SL;
      vid.frame_start <= 1'b0;
    end else begin
      vid.frame_start <= s1_ctl.start && s1_ctl.fs;
      if (s1_ctl.start) begin
        vid.rgb   <= s1_ctl.blank ? '0 : PAL[s1_color];
        vid.de    <= s1_ctl.de;
        vid.hsync <= s1_ctl.hs ^ SL;
        vid.vsync <= s1_ctl.vs ^ SL;
      end
    end
endmodule

// File: tb/tb_video_scanout.sv
// tb_video_scanout: two scaled-down scanouts (plain/active-low and overscan/active-high) against a time-based model
module tb_video_scanout;
  localparam int DIV = 2, HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 12, VFP = 1, VSY = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FR = HT * VT * DIV;
  localparam int OV [2] = '{0, 2};
  localparam bit SLO [2] = '{1'b1, 1'b0};
  typedef struct {
    logic [11:0] rgb;
    logic de, hs, vs, fs;
    bit rk;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] pn = '0;
  logic [5:0] pc = '0;
  logic pw = 1'b0;
  logic [5:0] mm [65536];
  bit mk [65536];
  exp_t e [2];
  logic [5:0] rd_val = '0;
  bit rd_known = 1'b0;
  bit chk_en = 1'b0;
  int k = 0;
  int checks = 0;
  int errors = 0;

  video_scanout_if if0();
  video_scanout_if if1();
  assign if0.pixel_num = pn;
  assign if0.pixel_color = pc;
  assign if0.pixel_write = pw;
  assign if1.pixel_num = pn;
  assign if1.pixel_color = pc;
  assign if1.pixel_write = pw;

  video_scanout #(.CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .OVERSCAN(0), .SYNC_LOW(1))
    dut0 (.clk(clk), .reset(reset), .vid(if0));
  video_scanout #(.CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .OVERSCAN(2), .SYNC_LOW(0))
    dut1 (.clk(clk), .reset(reset), .vid(if1));

  always #5 clk = ~clk;

  function automatic logic [12:0] bpal(logic [5:0] c);
    if (c == 6'h30) return {1'b1, 12'hFFF};
    if (c[3:0] >= 4'hD) return {1'b1, 12'h000};
    return '0;
  endfunction

  function automatic logic [5:0] pat(int x, int y);
    if (x == 0 && y == 0) return 6'h30;
    if (x == 15 && y == 0) return 6'h0F;
    if (x == 15 && y == 11) return 6'h30;
    return (x + y) % 3 == 0 ? 6'h30 : {2'(x), 4'(13 + (x + y) % 3)};
  endfunction

  function automatic int pk(int f, int x, int y);
    return f * FR + (y * HT + x) * DIV + 3;
  endfunction

  // k = clk edges since reset release; dot d is on the counters at k = d*DIV and at the outputs 3 clk later
  always @(posedge clk) begin
    if (reset) begin
      k = 0;
      for (int i = 0; i < 2; i++) e[i] = '{12'h000, 1'b0, SLO[i], SLO[i], 1'b0, 1'b1};
    end else begin
      k++;
      for (int i = 0; i < 2; i++) e[i].fs = 1'b0;
      if (k >= 3 && (k - 3) % DIV == 0) begin
        int d, h, v;
        bit on;
        d = (k - 3) / DIV;
        h = d % HT;
        v = (d / HT) % VT;
        on = h < HA && v < VA;
        for (int i = 0; i < 2; i++) begin
          logic [12:0] p;
          bit blank;
          blank = !on || v < OV[i] || v >= VA - OV[i];
          p = bpal(rd_val);
          e[i].de = on;
          e[i].hs = (h >= HA + HFP && h < HA + HFP + HS) ^ SLO[i];
          e[i].vs = (v >= VA + VFP && v < VA + VFP + VSY) ^ SLO[i];
          e[i].fs = d % (HT * VT) == 0;
          e[i].rgb = blank ? 12'h000 : p[11:0];
          e[i].rk = blank || (rd_known && p[12]);
        end
      end
      if (k >= 2 && (k - 2) % DIV == 0) begin
        int d, a;
        d = (k - 2) / DIV;
        a = ((d / HT) % VT) * 256 + d % HT;
        rd_val = mm[a];
        rd_known = mk[a];
      end
    end
    if (pw && pn < 16'hF000) begin
      mm[pn] = pc;
      mk[pn] = 1'b1;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (k=%0d)", nm, act, exp, k);
    end
  endtask

  task automatic cmp(input int i, input logic [11:0] rgb, input logic de, hs, vs, fs);
    if (e[i].rk) check($sformatf("dut%0d.rgb", i), rgb, e[i].rgb);
    check($sformatf("dut%0d.de", i), de, e[i].de);
    check($sformatf("dut%0d.hsync", i), hs, e[i].hs);
    check($sformatf("dut%0d.vsync", i), vs, e[i].vs);
    check($sformatf("dut%0d.frame_start", i), fs, e[i].fs);
  endtask

  always @(negedge clk)
    if (chk_en) begin
      cmp(0, if0.rgb, if0.de, if0.hsync, if0.vsync, if0.frame_start);
      cmp(1, if1.rgb, if1.de, if1.hsync, if1.vsync, if1.frame_start);
    end

  task automatic wr(input logic [15:0] a, input logic [5:0] c);
    pn = a;
    pc = c;
    pw = 1'b1;
    @(negedge clk);
    pw = 1'b0;
  endtask

  task automatic wait_k(input int t);
    int g = 0;
    while (k < t && g < 4 * FR) begin
      @(negedge clk);
      g++;
    end
    if (k < t) check("wait_k_timeout", k, t);
  endtask

  task automatic fs_latency(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if0.frame_start && n < 50);
    check(nm, n, 3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, m;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_de", if0.de, 0);
    check("reset_hsync_dut0", if0.hsync, 1);
    check("reset_vsync_dut1", if1.vsync, 0);
    reset = 1'b0;
    fs_latency("first_frame_start_clk");
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++) wr(16'(y * 256 + x), pat(x, y));
    wr(16'h00FF, 6'h0F);
    wr(16'hEFFF, 6'h30);
    wr(16'hF000, 6'h0F);
    wr(16'hFFFF, 6'h0F);
    wait_k(pk(1, 0, 0));
    check("pix00_rgb", if0.rgb, 12'hFFF);
    check("pix00_fs", if0.frame_start, 1);
    check("ovs00_rgb", if1.rgb, 12'h000);
    check("ovs00_de", if1.de, 1);
    wait_k(pk(1, 15, 0));
    check("pix15_0_rgb", if0.rgb, 12'h000);
    wait_k(pk(1, HA, 0));
    check("fp_de", if0.de, 0);
    check("fp_rgb", if0.rgb, 12'h000);
    wait_k(pk(1, 2, 1));
    check("pix2_1_rgb", if0.rgb, 12'hFFF);
    check("ovs2_1_rgb", if1.rgb, 12'h000);
    wait_k(pk(1, 1, 2));
    check("ovs1_2_rgb", if1.rgb, 12'hFFF);
    wait_k(pk(1, 15, 11));
    check("pix15_11_rgb", if0.rgb, 12'hFFF);
    check("ovs15_11_rgb", if1.rgb, 12'h000);
    check("ovs15_11_de", if1.de, 1);
    n = 0;
    while (!if0.hsync && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (if0.hsync && n < 200) begin @(negedge clk); n++; end
    check("dut1_hsync_pol", if1.hsync, 1);
    n = 0;
    while (!if0.hsync && n < 200) begin @(negedge clk); n++; end
    check("hsync_low_clk", n, HS * DIV);
    n = 0;
    while (!if0.vsync && n < 2 * FR) begin @(negedge clk); n++; end
    n = 0;
    while (if0.vsync && n < 2 * FR) begin @(negedge clk); n++; end
    check("dut1_vsync_pol", if1.vsync, 1);
    n = 0;
    while (!if0.vsync && n < 2 * FR) begin @(negedge clk); n++; end
    check("vsync_low_clk", n, VSY * HT * DIV);
    n = 0;
    while (!if0.frame_start && n < 2 * FR) begin @(negedge clk); n++; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if0.frame_start && n < 2 * FR);
    check("frame_period_clk", n, FR);
    m = pk(4, 4, 2) - 3;
    wait_k(m + 1);
    wr(16'(2 * 256 + 4), 6'h0F);
    wait_k(m + 3);
    check("read_first_old", if0.rgb, 12'hFFF);
    wait_k(m + FR + 3);
    check("read_first_new", if0.rgb, 12'h000);
    wait_k(pk(6, 5, 6));
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_de", if0.de, 0);
    check("midrst_hsync_dut0", if0.hsync, 1);
    check("midrst_hsync_dut1", if1.hsync, 0);
    check("midrst_rgb", if0.rgb, 12'h000);
    reset = 1'b0;
    fs_latency("restart_frame_start_clk");
    check("restart_rgb", if0.rgb, 12'hFFF);
    wait_k(FR + 40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
